// File: rtl/uart_baud_ctrl.sv
// rtl/uart_baud_ctrl.sv - UART baud divider: 16x oversample and bit ticks, safe divisor reload, RX re-phasing
module uart_baud_ctrl #(
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 54,
   parameter int OVERSAMPLE  = 16
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_wr,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ack,
   output logic             cfg_err,
   output logic             cfg_busy,
   input  logic             rx_sync,
   output logic             os_tick,
   output logic             bit_tick,
   output logic             active,
   output logic [CNT_W-1:0] div_cur
);
   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] div_nxt;
   logic [CNT_W-1:0] pend_div, pend_div_nxt;
   logic             pend_vld, pend_vld_nxt;
   logic [OS_W-1:0]  os_cnt, os_cnt_nxt;
   logic             ack_nxt, err_nxt;
   logic             run, wr_ok, tc;

   assign run      = (state == RUN);
   assign wr_ok    = cfg_wr && (cfg_div >= CNT_W'(2));
   assign tc       = (cnt == div_cur - CNT_W'(1));
   // A realign request steals the terminal-count cycle, so no tick escapes on the old grid
   assign os_tick  = run && tc && !rx_sync;
   assign bit_tick = os_tick && (os_cnt == OS_LAST);
   assign active   = run;
   assign cfg_busy = pend_vld;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      os_cnt_nxt   = os_cnt;
      div_nxt      = div_cur;
      pend_div_nxt = pend_div;
      pend_vld_nxt = pend_vld;
      ack_nxt      = 1'b0;
      err_nxt      = cfg_wr && !wr_ok;
      case (state)
         IDLE: begin
            cnt_nxt    = '0;
            os_cnt_nxt = '0;
            if (wr_ok) begin
               div_nxt      = cfg_div;
               pend_vld_nxt = 1'b0;
               ack_nxt      = 1'b1;
            end else if (pend_vld) begin
               div_nxt      = pend_div;
               pend_vld_nxt = 1'b0;
               ack_nxt      = 1'b1;
            end
            if (en) state_nxt = RUN;
         end
         RUN: begin
            if (!en) begin
               state_nxt  = IDLE;
               cnt_nxt    = '0;
               os_cnt_nxt = '0;
            end else if (rx_sync) begin
               cnt_nxt    = '0;
               os_cnt_nxt = OS_MID;
            end else if (tc) begin
               cnt_nxt    = '0;
               os_cnt_nxt = os_cnt + 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
            // Divisor only changes on a bit boundary (cnt already wraps there) or when leaving RUN
            if (pend_vld && (!en || bit_tick)) begin
               div_nxt      = pend_div;
               pend_vld_nxt = 1'b0;
               ack_nxt      = 1'b1;
            end
            if (wr_ok) begin
               pend_div_nxt = cfg_div;
               pend_vld_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         os_cnt   <= '0;
         div_cur  <= DIV_RST;
         pend_div <= DIV_RST;
         pend_vld <= 1'b0;
         cfg_ack  <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         os_cnt   <= os_cnt_nxt;
         div_cur  <= div_nxt;
         pend_div <= pend_div_nxt;
         pend_vld <= pend_vld_nxt;
         cfg_ack  <= ack_nxt;
         cfg_err  <= err_nxt;
      end
   end
endmodule
